sobel_frame_scheduler: RTL and testbench
========================================

# sobel_frame_scheduler

Frame-synchronous controller for the Sobel edge-detection datapath. It accepts threshold/enable configuration through a valid/ready handshake and holds each update in a pending register until the next start of frame, so the threshold never changes inside a frame. It also tracks frame state, checks every frame's geometry against the configured resolution, and counts frames. It sits beside the video image processor on the cmos pixel clock and drives that processor's Sobel threshold input plus a downstream Sobel/pass-through select.

## Interface
- IMG_HDISP, 640, expected clken-qualified pixels per href line
- IMG_VDISP, 480, expected href lines per frame
- THRESH_DEFAULT, 8'd40, threshold loaded at reset
- clk  in  1  cmos video pixel clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- per_frame_vsync  in  1  frame valid, high for the whole frame
- per_frame_href  in  1  line valid
- per_frame_clken  in  1  pixel enable
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  pending slot empty; transfer when cfg_valid & cfg_ready
- cfg_threshold  in  8  new Sobel threshold
- cfg_enable  in  1  1 = Sobel output, 0 = pass-through
- sobel_threshold  out  8  threshold applied to the current frame
- proc_enable  out  1  Sobel/pass-through select for the current frame
- frame_active  out  1  high while the scheduler is inside a tracked frame
- frame_done  out  1  one-cycle pulse at end of each tracked frame
- err_clr  in  1  clears geom_err
- geom_err  out  2  sticky: [0] line-length mismatch, [1] line-count mismatch
- frame_cnt  out  16  completed tracked frames, wraps

## Operation
- Edge detect: vsync and href are registered once. SOF is vsync=1 & vs_d=0. EOF is vsync=0 & vs_d=1. EOL is href=0 & hs_d=1.
- FSM states:
  - IDLE (reset state): wait for vsync=0, then go to WAIT_SOF. A frame already in progress at reset is ignored entirely.
  - WAIT_SOF: on SOF, go to ACTIVE.
  - ACTIVE: on EOF, go to WAIT_SOF.
- Config:
  - A transfer loads pend_thr/pend_en and sets pend_vld.
  - cfg_ready = !pend_vld; the output is registered.
  - On SOF in WAIT_SOF with pend_vld=1: sobel_threshold ← pend_thr, proc_enable ← pend_en, pend_vld ← 0.
  - A transfer in the same cycle as SOF does not affect that frame. It stays pending for the next SOF.
  - While pend_vld=1, further cfg_valid is back-pressured. The pending value is never overwritten.
- Geometry, ACTIVE only:
  - pix_cnt (11 bits, saturates at 2047) increments on href & clken and clears at EOL.
  - At EOL, pix_cnt ≠ IMG_HDISP sets geom_err[0]. line_cnt (10 bits, saturates at 1023) then increments.
  - At EOF, line_cnt ≠ IMG_VDISP sets geom_err[1]. Both counters then clear.
  - Counters also clear on SOF.
  - href/clken outside ACTIVE are ignored.
- EOF in ACTIVE: frame_done pulses and frame_cnt increments (0xFFFF → 0), regardless of errors.
- geom_err is sticky until err_clr. If err_clr and a new error occur in the same cycle, set wins.
- frame_active = (state == ACTIVE).

## Timing
- Reset values: sobel_threshold=THRESH_DEFAULT, proc_enable=1, cfg_ready=1, frame_active=0, frame_done=0, geom_err=0, frame_cnt=0. Pending register is cleared.
- SOF: sobel_threshold/proc_enable update, frame_active rises, and cfg_ready rises (if a pending slot was consumed) one clk after the first cycle vsync is sampled high.
- EOF: frame_done is high for exactly one cycle, starting one clk after the first cycle vsync is sampled low. frame_cnt and geom_err[1] update on the same edge.
- EOL: geom_err[0] updates one clk after the first cycle href is sampled low.
- The accepting edge is the edge where cfg_valid & cfg_ready; cfg_ready falls on the next cycle.
- SOF is recognised only in WAIT_SOF. A vsync glitch that goes high→low→high inside ACTIVE counts as EOF followed by SOF.
- rst asserted mid-frame: all state returns to reset values on the next edge and the FSM enters IDLE. No frame_done occurs until one full frame has been seen after reset.

## Test plan
- Reset, no config; 2 clean frames (bench IMG_HDISP=8, IMG_VDISP=4) -> sobel_threshold=40, proc_enable=1, two frame_done pulses, frame_cnt=2, geom_err=0.
- Mid-frame config (thr=0x55, en=0) -> cfg_ready falls, outputs unchanged until next SOF, then 0x55/0 one clk later, cfg_ready=1; second config while pending is stalled until that SOF.
- Config accepted on the exact SOF cycle -> current frame keeps the old threshold, new value applied at the following SOF.
- Frame with one 7-pixel line and only 3 lines -> geom_err=2'b11 after EOF, frame_done still pulses; err_clr -> 0; err_clr coincident with a new mismatch -> bit stays set.
- rst pulsed in mid-frame with vsync high -> no frame_done for that partial frame, frame_cnt=0, first count after the next full frame.
- Preload frame_cnt path through 65535 frames (or force) -> wraps to 0 with a normal frame_done pulse.

Source files
------------

// File: rtl/sobel_frame_scheduler.sv
// Frame-synchronous control for the Sobel datapath: double-buffered threshold/enable
// configuration applied only at start of frame, frame tracking, geometry checking
// and a completed-frame counter.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | after reset; waits for vsync low so a partial frame is skipped
// S_WAIT_SOF| between frames; waits for vsync rising edge
// S_ACTIVE  | inside a tracked frame; geometry counters run
module sobel_frame_scheduler #(
  parameter int          IMG_HDISP      = 640,
  parameter int          IMG_VDISP      = 480,
  parameter logic [7:0]  THRESH_DEFAULT = 8'd40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [7:0]  cfg_threshold,
  input  logic        cfg_enable,
  output logic [7:0]  sobel_threshold,
  output logic        proc_enable,
  output logic        frame_active,
  output logic        frame_done,
  input  logic        err_clr,
  output logic [1:0]  geom_err,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_SOF, S_ACTIVE} state_t;

  state_t      state, state_nxt;
  logic        vs_d, hs_d;
  logic        sof, eof, eol;
  logic        sof_take, eof_take, eol_take;
  logic        pend_vld, pend_en;
  logic [7:0]  pend_thr;
  logic        cfg_xfer;
  logic [10:0] pix_cnt;
  logic [9:0]  line_cnt;
  logic [9:0]  line_at_eof;
  logic [1:0]  err_set;
  logic [15:0] frame_cnt_q;

  assign sof = per_frame_vsync & ~vs_d;
  assign eof = ~per_frame_vsync & vs_d;
  assign eol = ~per_frame_href & hs_d;

  assign sof_take = sof & (state == S_WAIT_SOF);
  assign eof_take = eof & (state == S_ACTIVE);
  assign eol_take = eol & (state == S_ACTIVE);

  assign cfg_xfer  = cfg_valid & ~pend_vld;
  assign cfg_ready = ~pend_vld;
  assign frame_cnt = frame_cnt_q;

  // Delayed sync signals for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d <= 1'b0;
      hs_d <= 1'b0;
    end else begin
      vs_d <= per_frame_vsync;
      hs_d <= per_frame_href;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (!per_frame_vsync) state_nxt = S_WAIT_SOF;
      S_WAIT_SOF: if (sof)              state_nxt = S_ACTIVE;
      S_ACTIVE:   if (eof)              state_nxt = S_WAIT_SOF;
      default:                          state_nxt = S_IDLE;
    endcase
  end

  // Output decode from state.
  always_comb begin
    frame_active = (state == S_ACTIVE);
  end

  // Pending config slot; a transfer on the SOF cycle waits for the following SOF.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld        <= 1'b0;
      pend_thr        <= 8'd0;
      pend_en         <= 1'b0;
      sobel_threshold <= THRESH_DEFAULT;
      proc_enable     <= 1'b1;
    end else begin
      if (sof_take && pend_vld) begin
        sobel_threshold <= pend_thr;
        proc_enable     <= pend_en;
        pend_vld        <= 1'b0;
      end
      if (cfg_xfer) begin
        pend_thr <= cfg_threshold;
        pend_en  <= cfg_enable;
        pend_vld <= 1'b1;
      end
    end
  end

  // If href and vsync fall together, the closing line still counts toward the frame.
  always_comb begin
    line_at_eof = line_cnt;
    if (eol_take && line_cnt != 10'h3FF) line_at_eof = line_cnt + 10'd1;
    err_set[0] = eol_take && (pix_cnt != 11'(IMG_HDISP));
    err_set[1] = eof_take && (line_at_eof != 10'(IMG_VDISP));
  end

  // Saturating pixel and line counters, only advanced inside a tracked frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt  <= 11'd0;
      line_cnt <= 10'd0;
    end else begin
      if (sof_take || eof_take || eol_take)
        pix_cnt <= 11'd0;
      else if ((state == S_ACTIVE) && per_frame_href && per_frame_clken && pix_cnt != 11'h7FF)
        pix_cnt <= pix_cnt + 11'd1;
      if (sof_take || eof_take)
        line_cnt <= 10'd0;
      else if (eol_take && line_cnt != 10'h3FF)
        line_cnt <= line_cnt + 10'd1;
    end
  end

  // Sticky geometry errors (new error beats clear), end-of-frame pulse and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      geom_err    <= 2'b00;
      frame_done  <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      geom_err   <= (err_clr ? 2'b00 : geom_err) | err_set;
      frame_done <= eof_take;
      if (eof_take) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_sobel_frame_scheduler.sv
// Scoreboard bench for sobel_frame_scheduler: frame-level stimulus with a
// behavioural model of config buffering, geometry errors and frame counting.
module tb_sobel_frame_scheduler;
  localparam int HD = 8;
  localparam int VD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs = 1'b0, hs = 1'b0, ck = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [7:0]  cfg_threshold = 8'd0;
  logic        cfg_enable = 1'b0;
  logic [7:0]  sobel_threshold;
  logic        proc_enable, frame_active, frame_done;
  logic        err_clr = 1'b0;
  logic [1:0]  geom_err;
  logic [15:0] frame_cnt;

  sobel_frame_scheduler #(.IMG_HDISP(HD), .IMG_VDISP(VD), .THRESH_DEFAULT(8'd40)) dut (
    .clk(clk), .rst(rst),
    .per_frame_vsync(vs), .per_frame_href(hs), .per_frame_clken(ck),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_threshold(cfg_threshold), .cfg_enable(cfg_enable),
    .sobel_threshold(sobel_threshold), .proc_enable(proc_enable),
    .frame_active(frame_active), .frame_done(frame_done),
    .err_clr(err_clr), .geom_err(geom_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // reference model state
  bit          m_armed, m_active, m_pend, m_pen, m_en;
  logic [7:0]  m_pthr, m_thr;
  logic [1:0]  m_err;
  logic [15:0] m_cnt;
  // pending stimulus requests
  bit          req, req_en, clr_req;
  logic [7:0]  req_thr;

  typedef struct {
    logic [7:0]  thr;
    bit          en;
    logic [15:0] cnt;
    logic [1:0]  err;
  } rec_t;
  rec_t sbq[$];

  int  n_pass = 0, n_total = 0;
  bit  mon_en = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_armed = 0; m_active = 0; m_pend = 0; m_pen = 0; m_pthr = 8'd0;
    m_thr = 8'd40; m_en = 1; m_err = 2'b00; m_cnt = 16'd0;
  endtask

  task automatic do_reset(input bit v);
    vs = v; hs = 0; ck = 0; cfg_valid = 0; err_clr = 0; rst = 1;
    req = 0; clr_req = 0;
    @(posedge clk);
    model_reset();
    #1;
    rst = 0;
  endtask

  // one clock of stimulus; model follows the same edge
  task automatic step(input bit v, input bit h, input bit c, input bit apply_sof, input logic [1:0] set_err);
    bit acc;
    vs = v; hs = h; ck = c;
    cfg_valid = req; cfg_threshold = req_thr; cfg_enable = req_en; err_clr = clr_req;
    @(posedge clk);
    acc = req && !m_pend;
    if (apply_sof && m_pend) begin
      m_thr = m_pthr; m_en = m_pen; m_pend = 0;
    end
    if (acc) begin
      m_pend = 1; m_pthr = req_thr; m_pen = req_en; req = 0;
    end
    m_err = (clr_req ? 2'b00 : m_err) | set_err;
    clr_req = 0;
    if (!v) m_armed = 1;
    #1;
  endtask

  task automatic frame(input int nlines, input int short_line, input int cfg_line,
                       input logic [7:0] cthr, input bit cen, input int cfg2_line,
                       input bit cfg_at_sof, input int clr_line, input bit gaps);
    bit tr;
    int len;
    logic [1:0] se;
    tr = m_armed;
    if (cfg_at_sof) begin req = 1; req_thr = cthr; req_en = cen; end
    step(1, 0, 0, tr, 2'b00);
    m_active = tr;
    step(1, 0, 0, 0, 2'b00);
    for (int l = 0; l < nlines; l++) begin
      if (l == cfg_line)  begin req = 1; req_thr = cthr;  req_en = cen;  end
      if (l == cfg2_line) begin req = 1; req_thr = ~cthr; req_en = ~cen; end
      len = (l == short_line) ? HD - 1 : HD;
      for (int p = 0; p < len; p++) begin
        if (gaps && $urandom_range(0, 3) == 0) step(1, 1, 0, 0, 2'b00);
        step(1, 1, 1, 0, 2'b00);
      end
      if (l == clr_line) clr_req = 1;
      se = (tr && len != HD) ? 2'b01 : 2'b00;
      step(1, 0, 0, 0, se);
      step(1, 0, 0, 0, 2'b00);
    end
    se = (tr && nlines != VD) ? 2'b10 : 2'b00;
    step(0, 0, 0, 0, se);
    if (tr) begin
      m_cnt = m_cnt + 16'd1;
      sbq.push_back('{thr: m_thr, en: m_en, cnt: m_cnt, err: m_err});
    end
    m_active = 0;
    step(0, 0, 0, 0, 2'b00);
    step(0, 0, 0, 0, 2'b00);
  endtask

  // monitor: level checks every cycle, scoreboard pop on each frame_done
  always @(negedge clk) begin
    if (mon_en) begin
      rec_t r;
      chk("cfg_ready", 16'(cfg_ready), 16'(!m_pend));
      chk("sobel_threshold", 16'(sobel_threshold), 16'(m_thr));
      chk("proc_enable", 16'(proc_enable), 16'(m_en));
      chk("frame_active", 16'(frame_active), 16'(m_active));
      chk("geom_err", 16'(geom_err), 16'(m_err));
      if (frame_done === 1'b1) begin
        if (sbq.size() == 0) begin
          n_total++;
          $display("FAIL frame_done: pulse seen but no frame expected at %0t", $time);
        end else begin
          r = sbq.pop_front();
          chk("done_frame_cnt", frame_cnt, r.cnt);
          chk("done_geom_err", 16'(geom_err), 16'(r.err));
          chk("done_threshold", 16'(sobel_threshold), 16'(r.thr));
          chk("done_enable", 16'(proc_enable), 16'(r.en));
        end
      end
    end
  end

  initial begin
    model_reset();
    req = 0; req_en = 0; req_thr = 8'd0; clr_req = 0;
    do_reset(0);
    mon_en = 1;
    repeat (3) step(0, 0, 0, 0, 2'b00);

    // two clean frames with reset config
    frame(VD, -1, -1, 8'h00, 0, -1, 0, -1, 0);
    frame(VD, -1, -1, 8'h00, 0, -1, 0, -1, 1);
    chk("cnt_after_two", frame_cnt, 16'd2);

    // mid-frame config, then a second offer stalled while pending
    frame(VD, -1, 1, 8'h55, 0, 2, 0, -1, 0);
    frame(VD, -1, -1, 8'h00, 0, -1, 0, -1, 0);
    frame(VD, -1, -1, 8'h00, 0, -1, 0, -1, 0);

    // config offered exactly on the SOF cycle
    frame(VD, -1, -1, 8'h33, 1, -1, 1, -1, 0);
    frame(VD, -1, -1, 8'h00, 0, -1, 0, -1, 0);

    // bad geometry, clear, then clear coincident with a new line error
    frame(VD - 1, 0, -1, 8'h00, 0, -1, 0, -1, 0);
    clr_req = 1;
    step(0, 0, 0, 0, 2'b00);
    frame(VD, 1, -1, 8'h00, 0, -1, 0, 1, 0);
    clr_req = 1;
    step(0, 0, 0, 0, 2'b00);

    // reset in the middle of a tracked frame
    do_reset(0);
    step(0, 0, 0, 0, 2'b00);
    step(1, 0, 0, m_armed, 2'b00);
    m_active = 1;
    repeat (5) step(1, 1, 1, 0, 2'b00);
    do_reset(1);
    m_active = 0;
    for (int i = 0; i < 3; i++) begin
      repeat (HD) step(1, 1, 1, 0, 2'b00);
      step(1, 0, 0, 0, 2'b00);
    end
    step(0, 0, 0, 0, 2'b00);
    chk("cnt_after_rst", frame_cnt, 16'd0);
    step(0, 0, 0, 0, 2'b00);
    frame(VD, -1, -1, 8'h00, 0, -1, 0, -1, 0);

    // counter wrap
    force dut.frame_cnt_q = 16'hFFFE;
    #1;
    release dut.frame_cnt_q;
    m_cnt = 16'hFFFE;
    frame(VD, -1, -1, 8'h00, 0, -1, 0, -1, 0);
    frame(VD, -1, -1, 8'h00, 0, -1, 0, -1, 0);

    // randomized frames
    for (int f = 0; f < 30; f++) begin
      int nl, sl, cl, c2;
      nl = ($urandom_range(0, 4) == 0) ? VD - 1 + 2 * int'($urandom_range(0, 1)) : VD;
      sl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, VD - 1)) : -1;
      cl = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, VD - 1)) : -1;
      c2 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, VD - 1)) : -1;
      frame(nl, sl, cl, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), c2,
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, VD - 1)) : -1,
            1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        clr_req = 1;
        step(0, 0, 0, 0, 2'b00);
      end
    end

    repeat (5) step(0, 0, 0, 0, 2'b00);
    chk("scoreboard_drained", 16'(sbq.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
